// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the Goertzel tone detector.
// Holds the controller state encoding and the saturating adder used by the recurrence.
package goertzel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FIN1  = 3'd2,
    FIN2  = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int COEF_W_DEF = 18;
  localparam int COEF_FRAC  = COEF_W_DEF - 3;
  localparam logic [COEF_W_DEF-1:0] COEF_TWO = COEF_W_DEF'(2 << COEF_FRAC);

  // Wide enough for every intermediate at the default widths.
  localparam int WIDE = 128;

  typedef struct packed {
    logic            ovf;
    logic [WIDE-1:0] val;
  } sat_t;

  function automatic sat_t sat_add(input logic signed [WIDE-1:0] a,
                                   input logic signed [WIDE-1:0] b,
                                   input int unsigned            w);
    logic signed [WIDE-1:0] sum;
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    sat_t r;
    sum   = a + b;
    hi    = (WIDE'(1) <<< (w - 1)) - WIDE'(1);
    lo    = -hi - WIDE'(1);
    r.ovf = 1'b0;
    r.val = sum;
    if (sum > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (sum < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/goertzel_core.sv
// Goertzel recurrence datapath: s = x + floor(coef*s1 / 2^FRAC) - s2, saturated to ACC_W.
// The overflow flag is sticky until the next clear.
module goertzel_core
  import goertzel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     step_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [ACC_W-1:0]  s1_o,
  output logic signed [ACC_W-1:0]  s2_o,
  output logic                     ovf_o
);

  localparam int FRAC = COEF_W - 3;
  localparam int PW   = COEF_W + ACC_W;

  logic signed [ACC_W-1:0] s1_q;
  logic signed [ACC_W-1:0] s2_q;
  logic                    ovf_q;
  logic signed [PW-1:0]    prod;
  logic signed [WIDE-1:0]  fb_w;
  logic signed [WIDE-1:0]  in_w;
  sat_t                    s_d;

  assign prod = PW'(coef_i) * PW'(s1_q);
  assign fb_w = WIDE'(prod) >>> FRAC;
  assign in_w = WIDE'(x_i) - WIDE'(s2_q);
  assign s_d  = sat_add(fb_w, in_w, ACC_W);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      ovf_q <= 1'b0;
    end else if (step_i) begin
      s1_q  <= s_d.val[ACC_W-1:0];
      s2_q  <= s1_q;
      ovf_q <= ovf_q | s_d.ovf;
    end
  end

  assign s1_o  = s1_q;
  assign s2_o  = s2_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/goertzel_tone_detector.sv
// Block-based Goertzel power measurement with valid/ready input and output handshakes.
// Accepted samples are registered before the recurrence, so finalisation starts one cycle after the last accept.
module goertzel_tone_detector
  import goertzel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 12,
  parameter int OUT_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] coef,
  input  logic        [LEN_W-1:0]  n_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [OUT_W-1:0]  out_power,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int FRAC = COEF_W - 3;
  localparam int SQW  = 2 * ACC_W;
  localparam int CPW  = COEF_W + 2 * ACC_W;
  localparam int PWRW = CPW + 2;
  localparam logic signed [WIDE-1:0] OUT_MAX = {{(WIDE-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_t                    state_q, state_d;
  logic signed [COEF_W-1:0]  coef_q;
  logic        [LEN_W-1:0]   n_q;
  logic        [LEN_W-1:0]   count_q;
  logic                      step_q;
  logic signed [DATA_W-1:0]  x_q;
  logic signed [SQW-1:0]     p_a_q, p_b_q;
  logic signed [CPW-1:0]     p_c_q;
  logic        [OUT_W-1:0]   out_power_q, out_power_d;
  logic                      out_ovf_q, out_ovf_d;
  logic signed [ACC_W-1:0]   s1, s2;
  logic                      core_ovf;
  logic signed [PWRW-1:0]    pwr_full;
  logic signed [WIDE-1:0]    pwr_w;
  logic                      start_ok;
  logic                      accept;

  assign start_ok = (state_q == IDLE) && start && (n_len != '0);
  assign accept   = in_valid && in_ready;

  goertzel_core #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start_ok),
    .step_i  (step_q),
    .coef_i  (coef_q),
    .x_i     (x_q),
    .s1_o    (s1),
    .s2_o    (s2),
    .ovf_o   (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      coef_q      <= '0;
      n_q         <= '0;
      count_q     <= '0;
      step_q      <= 1'b0;
      x_q         <= '0;
      p_a_q       <= '0;
      p_b_q       <= '0;
      p_c_q       <= '0;
      out_power_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= accept;
      if (accept) x_q <= in_data;
      if (start_ok) begin
        coef_q  <= coef;
        n_q     <= n_len;
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + LEN_W'(1);
      end
      if (state_q == FIN1) begin
        p_a_q <= SQW'(s1) * SQW'(s1);
        p_b_q <= SQW'(s2) * SQW'(s2);
        p_c_q <= (CPW'(coef_q) * CPW'(s1) * CPW'(s2)) >>> FRAC;
      end
      if (state_q == FIN2) begin
        out_power_q <= out_power_d;
        out_ovf_q   <= out_ovf_d;
      end
    end
  end

  // Power at full precision, then clamp negatives to 0 and saturate above the output range.
  always_comb begin
    pwr_full    = PWRW'(p_a_q) + PWRW'(p_b_q) - PWRW'(p_c_q);
    pwr_w       = WIDE'(pwr_full);
    out_power_d = '0;
    out_ovf_d   = core_ovf;
    if (pwr_w > OUT_MAX) begin
      out_power_d = '1;
      out_ovf_d   = 1'b1;
    end else if (!pwr_w[WIDE-1]) begin
      out_power_d = pwr_w[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ACCUM;
      ACCUM:   if (count_q == n_q) state_d = FIN1;
      FIN1:    state_d = FIN2;
      FIN2:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM) && (count_q != n_q);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign out_power = out_power_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Directed and randomized bench for goertzel_tone_detector, checked against an arithmetic reference model.
// A second instance with ACC_W=20 shares all inputs to exercise recurrence saturation.
module tb_goertzel_tone_detector;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [17:0] coef;
  logic [11:0] n_len;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [63:0] out_power;
  logic        in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic [63:0] out_power_s;

  int n_chk  = 0;
  int n_fail = 0;
  int xs[$];

  always #5 clk = ~clk;

  goertzel_tone_detector #(.DATA_W(16), .COEF_W(18), .ACC_W(40), .LEN_W(12), .OUT_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .coef(coef), .n_len(n_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_power(out_power),
    .out_ovf(out_ovf), .busy(busy)
  );

  goertzel_tone_detector #(.DATA_W(16), .COEF_W(18), .ACC_W(20), .LEN_W(12), .OUT_W(64)) dut_s (
    .clk(clk), .rst(rst), .start(start), .coef(coef), .n_len(n_len),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_power(out_power_s),
    .out_ovf(out_ovf_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Reference: Goertzel on the sample list xs with the stated floor shift and saturations.
  function automatic void model(input int coefv, input int n, input int accw,
                                output logic [63:0] pwr, output logic ovf);
    logic signed [127:0] s1, s2, s, c, hi, lo, p, pmax;
    s1 = 0; s2 = 0; c = coefv; ovf = 1'b0;
    hi = (128'sd1 <<< (accw - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    pmax = {64'd0, {64{1'b1}}};
    for (int i = 0; i < n; i++) begin
      s = xs[i] + ((c * s1) >>> 15) - s2;
      if (s > hi) begin s = hi; ovf = 1'b1; end
      else if (s < lo) begin s = lo; ovf = 1'b1; end
      s2 = s1;
      s1 = s;
    end
    p = s1 * s1 + s2 * s2 - ((c * s1 * s2) >>> 15);
    if (p < 0) p = 0;
    else if (p > pmax) begin p = pmax; ovf = 1'b1; end
    pwr = p[63:0];
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_power"}, out_power, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
    chk({tag, "_ovf_s"}, out_ovf_s, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
  endtask

  task automatic run_block(input int coefv, input int n, input int gap_pct, input int stall,
                           input bit poke, input bit abort, output logic [63:0] pw);
    logic [63:0] ep, eps, held;
    logic        eo, eos;
    int          acc, budget, cyc, tmp;
    logic        rdy;
    model(coefv, n, 40, ep, eo);
    model(coefv, n, 20, eps, eos);
    start = 1'b1; coef = coefv[17:0]; n_len = n[11:0];
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    acc = 0; budget = 0;
    while (acc < n && budget < 4000) begin
      rdy      = in_ready;
      tmp      = xs[acc];
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = tmp[15:0];
      start    = poke && (acc == 1);
      if (start) begin n_len = 12'd3; coef = 18'h0abcd; end
      @(negedge clk);
      if (in_valid && rdy) acc++;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("samples_accepted", acc, n);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk("in_ready_low_fin", in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    chk("latency_edges", cyc, 3);
    chk("power", out_power, ep);
    chk("ovf", out_ovf, eo);
    chk("power_acc20", out_power_s, eps);
    chk("ovf_acc20", out_ovf_s, eos);
    pw   = out_power;
    held = out_power;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      start     = poke && (i == 0);
      @(negedge clk);
      start = 1'b0;
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out_power, held);
      chk("stall_in_ready", in_ready, 0);
    end
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset("rst_out");
      rst = 1'b0;
    end else begin
      out_ready = 1'b1;
      start     = poke;
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0;
      chk("post_hs_valid", out_valid, 0);
      chk("post_hs_busy", busy, 0);
    end
    $display("block coef=%0d n=%0d power=%0d ovf=%0d power20=%0d ovf20=%0d",
             coefv, n, pw, out_ovf, out_power_s, out_ovf_s);
  endtask

  task automatic fill(input int n, input int v);
    xs.delete();
    for (int i = 0; i < n; i++) xs.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    xs.delete();
    for (int i = 0; i < n; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
  endtask

  initial begin
    logic [63:0] pw;
    int          cv;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    coef = '0; n_len = '0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    fill(8, 100);
    run_block(65536, 8, 0, 1, 1'b0, 1'b0, pw);
    chk("dc_640000", pw, 64'd640000);

    xs = '{1000, 0, -1000, 0};
    run_block(0, 4, 0, 0, 1'b0, 1'b0, pw);
    chk("quarter_4e6", pw, 64'd4000000);
    fill(4, 0);
    run_block(0, 4, 0, 0, 1'b0, 1'b0, pw);
    chk("quarter_zero", pw, 64'd0);

    start = 1'b1; n_len = 12'd0; coef = 18'd65536;
    @(negedge clk);
    start = 1'b0;
    chk("nlen0_busy", busy, 0);
    chk("nlen0_in_ready", in_ready, 0);
    @(negedge clk);
    chk("nlen0_busy_later", busy, 0);

    fill(1, -300);
    run_block(int'($urandom_range(0, 262143)) - 131072, 1, 0, 0, 1'b0, 1'b0, pw);
    chk("n1_90000", pw, 64'd90000);

    fill_rand(10);
    run_block(int'($urandom_range(0, 262143)) - 131072, 10, 40, 5, 1'b1, 1'b0, pw);

    for (int b = 0; b < 6; b++) begin
      fill_rand(1 + (b * 7) % 20);
      cv = int'($urandom_range(0, 262143)) - 131072;
      run_block(cv, 1 + (b * 7) % 20, int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
                1'b0, 1'b0, pw);
    end

    fill(64, 32767);
    run_block(65536, 64, 0, 0, 1'b0, 1'b0, pw);
    chk("sat_ovf_acc20", out_ovf_s, 1);

    fill(8, 100);
    start = 1'b1; coef = 18'd65536; n_len = 12'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      in_valid = 1'b1; in_data = 16'd100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_accum");
    rst = 1'b0;
    @(negedge clk);

    fill(8, 100);
    run_block(65536, 8, 20, 2, 1'b0, 1'b1, pw);
    @(negedge clk);
    run_block(65536, 8, 0, 0, 1'b0, 1'b0, pw);
    chk("dc_after_reset", pw, 64'd640000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
